// File: rtl/reaction_timer_core.sv
// Multi-player reaction timer: tick prescaler, LFSR arming delay, saturating BCD
// reaction counter, false-start detection, winner indication and best-time register.
module reaction_timer_core #(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 100,
    parameter int PLAYERS         = 2,
    parameter int DIGITS          = 4,
    parameter int MIN_DELAY_TICKS = 200,
    parameter int RAND_BITS       = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  request,
    input  logic [PLAYERS-1:0]    stop,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [4*DIGITS-1:0]   best_bcd,
    output logic [PLAYERS-1:0]    winner,
    output logic                  waiting,
    output logic                  test_active,
    output logic                  done,
    output logic                  false_start,
    output logic                  overflow
);
    localparam int DIV   = CLK_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DLY_W = $clog2(MIN_DELAY_TICKS + (1 << RAND_BITS)) + 1;
    localparam int BW    = 4 * DIGITS;
    localparam logic [BW-1:0] ALL9  = {DIGITS{4'h9}};
    localparam logic [15:0]   RMASK = 16'((32'd1 << RAND_BITS) - 32'd1);

    typedef enum logic [2:0] {IDLE, ARMED, ACTIVE, DONE, FOUL} state_t;

    state_t             state, state_next;
    logic [PRE_W-1:0]   pre;
    logic [15:0]        lfsr;
    logic [DLY_W-1:0]   delay;
    logic               req_prev;
    logic [PLAYERS-1:0] stop_prev;
    logic               req_edge;
    logic [PLAYERS-1:0] stop_edge;
    logic               any_stop;
    logic               tick;
    logic [15:0]        r_val;
    logic               arm, go, foul_ev, stop_ev, count_ev, ovf_ev;

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // Saturating BCD increment: all 9s holds, otherwise ripple carry per digit.
    function automatic logic [BW-1:0] bcd_inc_sat(input logic [BW-1:0] v);
        logic [BW-1:0] r;
        logic          carry;
        r     = v;
        carry = 1'b1;
        if (v == ALL9) return v;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (v[4*i +: 4] == 4'h9) begin
                    r[4*i +: 4] = 4'h0;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] + 4'h1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [PLAYERS-1:0] lowest_set(input logic [PLAYERS-1:0] v);
        return v & (~v + PLAYERS'(1));
    endfunction

    assign req_edge  = request & ~req_prev;
    assign stop_edge = stop & ~stop_prev;
    assign any_stop  = |stop_edge;
    assign tick      = (pre == PRE_W'(DIV - 1));
    assign r_val     = lfsr & RMASK;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        arm         = 1'b0;
        go          = 1'b0;
        foul_ev     = 1'b0;
        stop_ev     = 1'b0;
        count_ev    = 1'b0;
        ovf_ev      = 1'b0;
        case (state)
            IDLE, DONE, FOUL: begin
                if (req_edge) begin
                    state_next = ARMED;
                    arm        = 1'b1;
                end
            end
            ARMED: begin
                if (any_stop) begin
                    state_next = FOUL;
                    foul_ev    = 1'b1;
                end else if (tick && delay == DLY_W'(1)) begin
                    state_next = ACTIVE;
                    go         = 1'b1;
                end
            end
            ACTIVE: begin
                // A stop edge wins over a coinciding tick, which is then not counted.
                if (any_stop) begin
                    state_next = DONE;
                    stop_ev    = 1'b1;
                end else if (tick) begin
                    if (bcd == ALL9) begin
                        state_next = DONE;
                        ovf_ev     = 1'b1;
                    end else begin
                        count_ev = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        waiting     = (state == ARMED);
        test_active = (state == ACTIVE);
        done        = (state == DONE);
        false_start = (state == FOUL);
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            pre       <= '0;
            lfsr      <= 16'hACE1;
            req_prev  <= 1'b0;
            stop_prev <= '0;
            delay     <= '0;
            bcd       <= '0;
            best_bcd  <= ALL9;
            winner    <= '0;
            overflow  <= 1'b0;
        end else begin
            lfsr      <= lfsr_step(lfsr);
            req_prev  <= request;
            stop_prev <= stop;
            if (arm || go || tick) pre <= '0;
            else                   pre <= pre + 1'b1;
            if (arm) begin
                bcd      <= '0;
                winner   <= '0;
                overflow <= 1'b0;
                delay    <= DLY_W'(MIN_DELAY_TICKS) + DLY_W'(r_val);
            end else if (state == ARMED && tick && !any_stop) begin
                delay <= delay - 1'b1;
            end
            if (foul_ev || stop_ev) winner <= lowest_set(stop_edge);
            if (stop_ev && bcd < best_bcd) best_bcd <= bcd;
            if (count_ev) bcd <= bcd_inc_sat(bcd);
            if (ovf_ev) begin
                overflow <= 1'b1;
                winner   <= '0;
            end
        end
    end
endmodule

// File: doc/reaction_timer_core.md
Name: reaction_timer_core

Overview:
Parametrised multi-player successor to the single-player reaction tester. It provides a tick prescaler, a pseudo-random arming delay from an LFSR, and a saturating BCD reaction counter. It also adds false-start detection, a winner indication and a best-time register that persists across rounds. It sits between the debounced button/virtual-input logic and the bcd7seg display decoders.

Parameters:
CLK_HZ, 50000000, input clock frequency
TICK_HZ, 100, count resolution (100 = hundredths of a second)
PLAYERS, 2, number of stop buttons (1..8)
DIGITS, 4, BCD digits in the reaction and best-time counters (1..8)
MIN_DELAY_TICKS, 200, fixed part of the arming delay in ticks (>=1)
RAND_BITS, 8, width of the random part of the arming delay (0..RAND_BITS max = 2^RAND_BITS-1 ticks)

Ports:
CLOCK_50  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high; clears all state
request  in  1  start request, level; synchronous and debounced upstream; rising edge used
stop  in  PLAYERS  per-player stop buttons, level; synchronous and debounced; rising edges used
bcd  out  4*DIGITS  current reaction time; digit 0 = bits [3:0], least significant
best_bcd  out  4*DIGITS  best valid time since reset
winner  out  PLAYERS  one-hot player that ended the round (stop or foul)
waiting  out  1  high in ARMED
test_active  out  1  high in ACTIVE
done  out  1  high in DONE
false_start  out  1  high in FOUL
overflow  out  1  sticky for the round: counter saturated

Behaviour:
- Reset values:
  - state IDLE; bcd = 0, best_bcd = all 9s, winner = 0, all flags 0.
  - prescaler = 0, LFSR = 16'hACE1, edge-detect registers = 0.
- Edge detect: a rising edge is current = 1 and previous registered = 0. The previous registers update every clock.
- Tick:
  - Prescaler counts 0..CLK_HZ/TICK_HZ-1 and pulses tick for one clock at the terminal count.
  - Prescaler is cleared on every entry to ARMED and ACTIVE, so the first tick comes exactly one full period later.
- LFSR:
  - 16-bit Galois, taps 16,14,13,11, free-running every clock.
  - r = low RAND_BITS bits, sampled on the request edge.
- States and transitions:
  - IDLE / DONE / FOUL + request edge -> ARMED next clock.
    - On this transition: bcd = 0, winner = 0, overflow = 0, flags cleared, delay = MIN_DELAY_TICKS + r.
    - A stop edge in the same cycle is ignored.
  - ARMED + any stop edge -> FOUL.
    - winner = lowest-indexed player with an edge; bcd stays 0.
    - A stop edge takes priority over a coinciding final tick.
  - ARMED + tick: delay decrements. When tick occurs with delay == 1 -> ACTIVE.
    - ARMED therefore lasts (MIN_DELAY_TICKS + r) ticks.
  - ACTIVE + stop edge -> DONE.
    - winner = lowest-indexed player with an edge.
    - A coinciding tick is NOT counted.
  - ACTIVE + tick, no stop edge: bcd increments as a BCD number; each digit 9 -> 0 carries upward.
  - ACTIVE + tick at all 9s: bcd holds all 9s, overflow = 1, -> DONE, winner = 0.
  - Request edges in ARMED and ACTIVE are ignored.
- Best time:
  - Updated on the ACTIVE -> DONE transition only if caused by a stop edge and bcd < best_bcd.
  - Packed BCD is compared as an unsigned binary value.
  - FOUL and overflow rounds never update best_bcd. Only reset restores all 9s.
- Latency:
  - Stop edge sampled at clock t -> state, flags, winner and best_bcd valid after clock t+1; bcd frozen from t+1.
  - The flags are decodes of the state register, with no extra delay.
- Reset mid-round: immediate return to the reset values, including best_bcd.

Test Plan:
Bench config for all scenarios: CLK_HZ=1000, TICK_HZ=100 (10 clk/tick), MIN_DELAY_TICKS=3, RAND_BITS=2, PLAYERS=2, DIGITS=2.
1. Reset asserted mid-ACTIVE with bcd=07 -> bcd=00, best_bcd=99, all flags 0, state IDLE without a clock edge.
2. Request edge; force the LFSR low bits to r=1 by timing the request -> waiting high for exactly 40 clocks, then test_active; stop[1] edge after 5 ticks -> done=1, bcd=05, winner=2'b10, best_bcd=05.
3. Second round: stop[0] after 8 ticks -> bcd=08, best_bcd stays 05. Third round at 3 ticks -> best_bcd=03.
4. Both stop bits rise during ARMED -> false_start=1, winner=2'b01, bcd=00, best_bcd unchanged; a request edge re-arms and clears the flags.
5. No stop in ACTIVE -> bcd runs 09->10 (carry checked), then reaches 99 -> on the next tick overflow=1, done=1, winner=0, bcd=99, best_bcd unchanged.
6. Stop edge on the same clock as a tick in ACTIVE with bcd=04 -> bcd stays 04. Request edge and stop edge together in IDLE -> ARMED entered, no foul.
